// File: rtl/bilinear_frame_ctrl_if.sv
// Coordinate request channel from the frame sequencer to the coordinate/memory pipeline.
// The sequencer drives the request and its flags; the downstream side returns ready.
interface bilinear_frame_ctrl_if;
  logic       coord_valid;
  logic       ready;
  logic [9:0] coordinate_x;
  logic [9:0] coordinate_y;
  logic [7:0] frac_x;
  logic [7:0] frac_y;
  logic       line_last;
  logic       frame_last;

  modport master (
    output coord_valid,
    output coordinate_x,
    output coordinate_y,
    output frac_x,
    output frac_y,
    output line_last,
    output frame_last,
    input  ready
  );

  modport slave (
    input  coord_valid,
    input  coordinate_x,
    input  coordinate_y,
    input  frac_x,
    input  frac_y,
    input  line_last,
    input  frame_last,
    output ready
  );
endinterface

// File: rtl/bilinear_frame_ctrl.sv
// Raster-order frame sequencer producing Q10.8 DDA source coordinates per destination pixel.
// Optional BILINEAR_EDGE_CLAMP_EN keeps both interpolation neighbours inside the source image.
module bilinear_frame_ctrl #(
  parameter int SRC_WIDTH  = 100,
  parameter int SRC_HEIGHT = 100,
  parameter int DST_WIDTH  = 200,
  parameter int DST_HEIGHT = 200
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [9:0]                   step_x,
  input  logic [9:0]                   step_y,
  output logic                         busy,
  output logic                         done,
  bilinear_frame_ctrl_if.master        cif
);

  if (SRC_WIDTH < 2 || SRC_HEIGHT < 2) begin : g_bad_src
    $error("bilinear_frame_ctrl: source dimensions must be at least 2");
  end
  if (DST_WIDTH < 1 || DST_WIDTH > 1023 || DST_HEIGHT < 1 || DST_HEIGHT > 1023) begin : g_bad_dst
    $error("bilinear_frame_ctrl: destination dimensions must be 1..1023");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WRAP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [9:0] LAST_X = 10'(DST_WIDTH - 1);
  localparam logic [9:0] LAST_Y = 10'(DST_HEIGHT - 1);

  state_t      state_q, state_d;
  logic [9:0]  step_x_q, step_x_d;
  logic [9:0]  step_y_q, step_y_d;
  logic [17:0] acc_x_q, acc_x_d;
  logic [17:0] acc_y_q, acc_y_d;
  logic [9:0]  dst_x_q, dst_x_d;
  logic [9:0]  dst_y_q, dst_y_d;

  logic        run;
  logic        handshake;
  logic        at_line_end;
  logic        at_frame_end;
  logic [17:0] out_x;
  logic [17:0] out_y;

  assign run          = (state_q == RUN);
  assign handshake    = run && cif.ready;
  assign at_line_end  = (dst_x_q == LAST_X);
  assign at_frame_end = at_line_end && (dst_y_q == LAST_Y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      step_x_q <= '0;
      step_y_q <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      dst_x_q  <= '0;
      dst_y_q  <= '0;
    end else begin
      state_q  <= state_d;
      step_x_q <= step_x_d;
      step_y_q <= step_y_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      dst_x_q  <= dst_x_d;
      dst_y_q  <= dst_y_d;
    end
  end

  // Everything holds unless a handshake, a line wrap or a frame start moves it,
  // which is what keeps the request stable under backpressure.
  always_comb begin
    state_d  = state_q;
    step_x_d = step_x_q;
    step_y_d = step_y_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    dst_x_d  = dst_x_q;
    dst_y_d  = dst_y_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          step_x_d = step_x;
          step_y_d = step_y;
          acc_x_d  = '0;
          acc_y_d  = '0;
          dst_x_d  = '0;
          dst_y_d  = '0;
        end
      end
      RUN: begin
        if (handshake) begin
          if (at_frame_end) begin
            state_d = DONE;
          end else if (at_line_end) begin
            state_d = WRAP;
          end else begin
            acc_x_d = acc_x_q + {8'd0, step_x_q};
            dst_x_d = dst_x_q + 10'd1;
          end
        end
      end
      WRAP: begin
        state_d = RUN;
        acc_x_d = '0;
        dst_x_d = '0;
        acc_y_d = acc_y_q + {8'd0, step_y_q};
        dst_y_d = dst_y_q + 10'd1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef BILINEAR_EDGE_CLAMP_EN
  localparam logic [9:0] SRC_X_LAST  = 10'(SRC_WIDTH - 1);
  localparam logic [9:0] SRC_X_CLAMP = 10'(SRC_WIDTH - 2);
  localparam logic [9:0] SRC_Y_LAST  = 10'(SRC_HEIGHT - 1);
  localparam logic [9:0] SRC_Y_CLAMP = 10'(SRC_HEIGHT - 2);

  // Pin to the second-to-last sample with full weight on the far neighbour.
  function automatic logic [17:0] edge_clamp(input logic [17:0] acc,
                                             input logic [9:0]  last,
                                             input logic [9:0]  clamp_to);
    logic [17:0] res;
    if (acc[17:8] >= last) begin
      res = {clamp_to, 8'hFF};
    end else begin
      res = acc;
    end
    return res;
  endfunction

  assign out_x = edge_clamp(acc_x_q, SRC_X_LAST, SRC_X_CLAMP);
  assign out_y = edge_clamp(acc_y_q, SRC_Y_LAST, SRC_Y_CLAMP);
`else
  assign out_x = acc_x_q;
  assign out_y = acc_y_q;
`endif

  assign cif.coord_valid  = run;
  assign cif.coordinate_x = out_x[17:8];
  assign cif.frac_x       = out_x[7:0];
  assign cif.coordinate_y = out_y[17:8];
  assign cif.frac_y       = out_y[7:0];
  assign cif.line_last    = run && at_line_end;
  assign cif.frame_last   = run && at_frame_end;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
